// File: rtl/lsu_misalign_seq_pkg.sv
// Shared types and helpers for the LSU misaligned-access sequencer.
package lsu_misalign_seq_pkg;

    typedef enum logic [1:0] {
        LSU_W = 2'b00,
        LSU_H = 2'b01,
        LSU_B = 2'b10
    } lsu_type_e;

    typedef logic [2:0] lsu_seq_state_e;

    localparam lsu_seq_state_e S_IDLE            = 3'd0;
    localparam lsu_seq_state_e S_WAIT_GNT_MIS    = 3'd1;
    localparam lsu_seq_state_e S_WAIT_RVALID_MIS = 3'd2;
    localparam lsu_seq_state_e S_WAIT_GNT        = 3'd3;
    localparam lsu_seq_state_e S_WAIT_RVALID     = 3'd4;

    // An access needs two bus beats when it crosses a word boundary.
    function automatic logic is_misaligned(input logic [1:0] t, input logic [1:0] off);
        return ((t == LSU_W) && (off != 2'b00)) || ((t == LSU_H) && (off == 2'b11));
    endfunction

    function automatic logic [3:0] be_first(input logic [1:0] t, input logic [1:0] off);
        case (t)
            LSU_W:   return 4'hF << off;
            LSU_H:   return (off == 2'b11) ? 4'b1000 : (4'b0011 << off);
            LSU_B:   return 4'b0001 << off;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] be_second(input logic [1:0] t, input logic [1:0] off);
        if (t == LSU_W) return 4'hF >> (3'd4 - {1'b0, off});
        return 4'b0001;
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] off);
        return 32'(({w, w} << {off, 3'b000}) >> 32);
    endfunction

endpackage

// File: rtl/lsu_misalign_seq_rdata_align.sv
// Load data alignment across one or two bus words, followed by half/byte extension.
module lsu_rdata_align
    import lsu_misalign_seq_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [1:0]  off_i,
    input  logic        split_i,
    input  logic [1:0]  type_i,
    input  logic        sign_ext_i,
    output logic [31:0] rdata_o
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] sh;

    assign hi = split_i ? rdata_i : 32'h0;
    assign lo = split_i ? rdata_lo_i : rdata_i;
    assign sh = 32'({hi, lo} >> {off_i, 3'b000});

    always_comb begin
        rdata_o = sh;
        case (type_i)
            LSU_H:   rdata_o = {{16{sign_ext_i & sh[15]}}, sh[15:0]};
            LSU_B:   rdata_o = {{24{sign_ext_i & sh[7]}}, sh[7:0]};
            default: rdata_o = sh;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_seq.sv
// Sequences EX loads/stores onto the data bus, splitting word-crossing accesses into two beats.
module lsu_misalign_seq
    import lsu_misalign_seq_pkg::*;
#(
    parameter int unsigned RvalidTimeout = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        addr_incr_req_o,
    output logic [31:0] addr_last_o,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o
);

    localparam int unsigned CntW = (RvalidTimeout > 1) ? $clog2(RvalidTimeout) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'((RvalidTimeout == 0) ? 0 : RvalidTimeout - 1);

    lsu_seq_state_e state_q, state_d;
    logic [31:0]    addr_q, addr_last_q, wdata_q, rdata_lo_q;
    logic [3:0]     be_q;
    logic           we_q, mis_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        req, capture, first, mis_c, incr, done, err, tmo, we_c;
    logic [31:0] addr_c, wdata_c, rdata_aligned;
    logic [3:0]  be_c;

    assign tmo = (RvalidTimeout != 0) && (cnt_q == TmoLast);

    // Next state, bus request generation and completion.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        addr_c  = addr_q;
        be_c    = be_q;
        we_c    = we_q;
        wdata_c = wdata_q;
        capture = 1'b0;
        first   = 1'b0;
        mis_c   = 1'b0;
        incr    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    req     = 1'b1;
                    addr_c  = {adder_result_ex_i[31:2], 2'b00};
                    be_c    = be_first(lsu_type_i, adder_result_ex_i[1:0]);
                    we_c    = lsu_we_i;
                    wdata_c = rotl_bytes(lsu_wdata_i, adder_result_ex_i[1:0]);
                    capture = 1'b1;
                    first   = 1'b1;
                    mis_c   = is_misaligned(lsu_type_i, adder_result_ex_i[1:0]);
                    if (data_gnt_i) state_d = mis_c ? S_WAIT_RVALID_MIS : S_WAIT_RVALID;
                    else            state_d = mis_c ? S_WAIT_GNT_MIS : S_WAIT_GNT;
                end
            end
            S_WAIT_GNT_MIS: begin
                req = 1'b1;
                if (data_gnt_i) state_d = S_WAIT_RVALID_MIS;
            end
            S_WAIT_RVALID_MIS: begin
                incr = 1'b1;
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        done    = 1'b1;
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // ALU now presents addr_last+4, so the second beat issues immediately.
                        req     = 1'b1;
                        addr_c  = {adder_result_ex_i[31:2], 2'b00};
                        be_c    = be_second(lsu_type_i, addr_last_q[1:0]);
                        we_c    = lsu_we_i;
                        wdata_c = rotl_bytes(lsu_wdata_i, addr_last_q[1:0]);
                        capture = 1'b1;
                        state_d = data_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                    end
                end else if (tmo) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_GNT: begin
                req = 1'b1;
                if (data_gnt_i) state_d = S_WAIT_RVALID;
            end
            S_WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    done    = 1'b1;
                    err     = data_err_i;
                    state_d = S_IDLE;
                end else if (tmo) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req && data_gnt_i) begin
            cnt_d = '0;
        end else if ((state_q == S_WAIT_RVALID_MIS) || (state_q == S_WAIT_RVALID)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            addr_last_q <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_lo_q  <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= addr_c;
                be_q    <= be_c;
                we_q    <= we_c;
                wdata_q <= wdata_c;
            end
            if (first) begin
                addr_last_q <= adder_result_ex_i;
                mis_q       <= mis_c;
            end
            if ((state_q == S_WAIT_RVALID_MIS) && data_rvalid_i) begin
                rdata_lo_q <= data_rdata_i;
            end
        end
    end

    lsu_rdata_align u_rdata_align (
        .rdata_i    (data_rdata_i),
        .rdata_lo_i (rdata_lo_q),
        .off_i      (addr_last_q[1:0]),
        .split_i    (mis_q),
        .type_i     (lsu_type_i),
        .sign_ext_i (lsu_sign_ext_i),
        .rdata_o    (rdata_aligned)
    );

    // Bus fields are zero whenever no request is presented.
    assign data_req_o      = req;
    assign data_addr_o     = req ? addr_c : 32'h0;
    assign data_be_o       = req ? be_c : 4'h0;
    assign data_we_o       = req & we_c;
    assign data_wdata_o    = req ? wdata_c : 32'h0;
    assign addr_incr_req_o = incr;
    assign addr_last_o     = addr_last_q;
    assign lsu_busy_o      = (state_q != S_IDLE);
    assign lsu_done_o      = done;
    assign lsu_err_o       = err;
    assign lsu_rdata_o     = (done && !we_q) ? rdata_aligned : 32'h0;

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Directed bench for lsu_misalign_seq with an ALU model feeding the operand-A mux.
module tb_lsu_misalign_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we, lsu_sign_ext;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_wdata, base_addr, adder;
    logic        data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        addr_incr_req, lsu_busy, lsu_done, lsu_err;
    logic [31:0] addr_last, lsu_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign adder = addr_incr_req ? (addr_last + 32'd4) : base_addr;

    lsu_misalign_seq #(.RvalidTimeout(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .lsu_req_i         (lsu_req),
        .lsu_we_i          (lsu_we),
        .lsu_type_i        (lsu_type),
        .lsu_sign_ext_i    (lsu_sign_ext),
        .lsu_wdata_i       (lsu_wdata),
        .adder_result_ex_i (adder),
        .data_req_o        (data_req),
        .data_gnt_i        (data_gnt),
        .data_addr_o       (data_addr),
        .data_we_o         (data_we),
        .data_be_o         (data_be),
        .data_wdata_o      (data_wdata),
        .data_rvalid_i     (data_rvalid),
        .data_err_i        (data_err),
        .data_rdata_i      (data_rdata),
        .addr_incr_req_o   (addr_incr_req),
        .addr_last_o       (addr_last),
        .lsu_busy_o        (lsu_busy),
        .lsu_done_o        (lsu_done),
        .lsu_err_o         (lsu_err),
        .lsu_rdata_o       (lsu_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_err    = 1'b0;
        data_rdata  = 32'h0;
    endtask

    task automatic start(input logic we, input logic [1:0] t, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        lsu_req      = 1'b1;
        lsu_we       = we;
        lsu_type     = t;
        lsu_sign_ext = sx;
        base_addr    = a;
        lsu_wdata    = wd;
    endtask

    task automatic finish_idle();
        tick();
        lsu_req = 1'b0;
        bus_idle();
        mid();
        chk("idle_busy", 32'(lsu_busy), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00; lsu_sign_ext = 1'b0;
        lsu_wdata = 32'h0; base_addr = 32'h0;
        bus_idle();
        tick();
        tick();
        mid();
        chk("rst_req",   32'(data_req), 32'h0);
        chk("rst_busy",  32'(lsu_busy), 32'h0);
        chk("rst_last",  addr_last, 32'h0);
        chk("rst_done",  32'(lsu_done), 32'h0);
        rst = 1'b0;

        // Aligned LW 0x1000
        tick();
        start(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
        data_gnt = 1'b1;
        mid();
        chk("lw_req",  32'(data_req), 32'h1);
        chk("lw_addr", data_addr, 32'h1000);
        chk("lw_be",   32'(data_be), 32'hF);
        chk("lw_incr0", 32'(addr_incr_req), 32'h0);
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hDEADBEEF;
        mid();
        chk("lw_done",  32'(lsu_done), 32'h1);
        chk("lw_err",   32'(lsu_err), 32'h0);
        chk("lw_rdata", lsu_rdata, 32'hDEADBEEF);
        chk("lw_incr1", 32'(addr_incr_req), 32'h0);
        finish_idle();

        // Split LW 0x1002
        tick();
        start(1'b0, 2'b00, 1'b0, 32'h1002, 32'h0);
        data_gnt = 1'b1;
        mid();
        chk("lwm_addr1", data_addr, 32'h1000);
        chk("lwm_be1",   32'(data_be), 32'hC);
        tick();
        data_rvalid = 1'b1; data_rdata = 32'hAABBCCDD;
        mid();
        chk("lwm_incr",  32'(addr_incr_req), 32'h1);
        chk("lwm_last",  addr_last, 32'h1002);
        chk("lwm_req2",  32'(data_req), 32'h1);
        chk("lwm_addr2", data_addr, 32'h1004);
        chk("lwm_be2",   32'(data_be), 32'h3);
        chk("lwm_nodone", 32'(lsu_done), 32'h0);
        tick();
        data_gnt = 1'b0; data_rdata = 32'h11223344;
        mid();
        chk("lwm_done",  32'(lsu_done), 32'h1);
        chk("lwm_rdata", lsu_rdata, 32'h3344AABB);
        chk("lwm_incr2", 32'(addr_incr_req), 32'h0);
        finish_idle();

        // Split SH 0x2003 with three-cycle grant delays
        tick();
        start(1'b1, 2'b01, 1'b0, 32'h2003, 32'h0000BEEF);
        mid();
        chk("sh_addr1", data_addr, 32'h2000);
        chk("sh_be1",   32'(data_be), 32'h8);
        chk("sh_wd1",   data_wdata, 32'hEF0000BE);
        chk("sh_we1",   32'(data_we), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            base_addr = 32'h5555_5555;
            mid();
            chk("sh_hold_req",  32'(data_req), 32'h1);
            chk("sh_hold_addr", data_addr, 32'h2000);
            chk("sh_hold_be",   32'(data_be), 32'h8);
        end
        tick();
        data_gnt = 1'b1;
        mid();
        chk("sh_gnt_addr", data_addr, 32'h2000);
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h12345678;
        mid();
        chk("sh_incr",  32'(addr_incr_req), 32'h1);
        chk("sh_addr2", data_addr, 32'h2004);
        chk("sh_be2",   32'(data_be), 32'h1);
        chk("sh_wd2",   data_wdata, 32'hEF0000BE);
        for (int i = 0; i < 2; i++) begin
            tick();
            data_rvalid = 1'b0;
            mid();
            chk("sh_hold2_addr", data_addr, 32'h2004);
            chk("sh_hold2_be",   32'(data_be), 32'h1);
        end
        tick();
        data_gnt = 1'b1;
        mid();
        chk("sh_gnt2_req", 32'(data_req), 32'h1);
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1;
        mid();
        chk("sh_done",  32'(lsu_done), 32'h1);
        chk("sh_rdata", lsu_rdata, 32'h0);
        finish_idle();

        // LB signed 0x3001
        tick();
        start(1'b0, 2'b10, 1'b1, 32'h3001, 32'h0);
        data_gnt = 1'b1;
        mid();
        chk("lb_be", 32'(data_be), 32'h2);
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h0000800F;
        mid();
        chk("lb_rdata", lsu_rdata, 32'hFFFFFF80);
        finish_idle();

        // LH signed 0x3002
        tick();
        start(1'b0, 2'b01, 1'b1, 32'h3002, 32'h0);
        data_gnt = 1'b1;
        mid();
        chk("lh_be", 32'(data_be), 32'hC);
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h80010000;
        mid();
        chk("lh_rdata", lsu_rdata, 32'hFFFF8001);
        finish_idle();

        // LW 0x1001, first beat errors
        tick();
        start(1'b0, 2'b00, 1'b0, 32'h1001, 32'h0);
        data_gnt = 1'b1;
        mid();
        chk("lwe_be", 32'(data_be), 32'hE);
        tick();
        data_gnt = 1'b1; data_rvalid = 1'b1; data_err = 1'b1;
        mid();
        chk("lwe_done", 32'(lsu_done), 32'h1);
        chk("lwe_err",  32'(lsu_err), 32'h1);
        chk("lwe_noreq", 32'(data_req), 32'h0);
        finish_idle();

        // Timeout: grant then no response
        tick();
        start(1'b0, 2'b00, 1'b0, 32'h4000, 32'h0);
        data_gnt = 1'b1;
        mid();
        for (int i = 1; i <= 4; i++) begin
            tick();
            data_gnt = 1'b0;
            mid();
            chk("tmo_done", 32'(lsu_done), (i == 4) ? 32'h1 : 32'h0);
            chk("tmo_err",  32'(lsu_err),  (i == 4) ? 32'h1 : 32'h0);
        end
        finish_idle();

        // rvalid on the timeout cycle wins
        tick();
        start(1'b0, 2'b00, 1'b0, 32'h4000, 32'h0);
        data_gnt = 1'b1;
        mid();
        for (int i = 1; i <= 4; i++) begin
            tick();
            data_gnt = 1'b0;
            if (i == 4) begin
                data_rvalid = 1'b1;
                data_rdata  = 32'hCAFEF00D;
            end
            mid();
        end
        chk("race_done",  32'(lsu_done), 32'h1);
        chk("race_err",   32'(lsu_err), 32'h0);
        chk("race_rdata", lsu_rdata, 32'hCAFEF00D);
        finish_idle();

        // Reset while waiting for the first split grant
        tick();
        start(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);
        mid();
        tick();
        mid();
        chk("rstm_busy", 32'(lsu_busy), 32'h1);
        tick();
        rst = 1'b1;
        lsu_req = 1'b0;
        mid();
        tick();
        rst = 1'b0;
        mid();
        chk("rstm_busy0", 32'(lsu_busy), 32'h0);
        chk("rstm_req0",  32'(data_req), 32'h0);
        chk("rstm_last0", addr_last, 32'h0);
        chk("rstm_addr0", data_addr, 32'h0);
        chk("rstm_be0",   32'(data_be), 32'h0);
        chk("rstm_incr0", 32'(addr_incr_req), 32'h0);
        tick();
        data_gnt = 1'b1; data_rvalid = 1'b1; data_rdata = 32'hFFFFFFFF;
        mid();
        chk("stale_done",  32'(lsu_done), 32'h0);
        chk("stale_rdata", lsu_rdata, 32'h0);
        tick();
        mid();
        chk("stale_busy", 32'(lsu_busy), 32'h0);
        bus_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
